// File: rtl/seq_mult_nbit.sv
// Sequential N-bit unsigned shift-and-add multiplier built around a ripple-carry adder.
// Optional early termination is compiled in with `define SEQ_MULT_EARLY_DONE_EN.

module rca_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Bit-serial carry chain; a scalar carry variable keeps the chain acyclic.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < int'(N); i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

module seq_mult_nbit #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    mcand;
  logic [N-1:0]    upper;
  logic [N-1:0]    lower;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    addend;
  logic [N-1:0]    sum;
  logic            cout;
  logic [PW-1:0]   shifted;
  logic [PW-1:0]   product;
  logic            last;

  assign addend  = lower[0] ? mcand : '0;
  assign shifted = {cout, sum, lower[N-1:1]};

  rca_nbit #(.N(N)) u_add (
    .x    (upper),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef SEQ_MULT_EARLY_DONE_EN
  // Unprocessed multiplier bits; finish once none of them is set.
  logic [N-1:0]  rem;
  logic [CW-1:0] shamt;

  assign shamt   = CW'(N - 1) - cnt;
  assign last    = (cnt == CW'(N - 1)) || ((rem >> 1) == '0);
  assign product = shifted >> shamt;
`else
  assign last    = (cnt == CW'(N - 1));
  assign product = shifted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      upper <= '0;
      lower <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
`ifdef SEQ_MULT_EARLY_DONE_EN
      rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            upper <= '0;
            lower <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SEQ_MULT_EARLY_DONE_EN
            rem   <= b;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          upper <= shifted[PW-1:N];
          lower <= shifted[N-1:0];
          cnt   <= cnt + CW'(1);
`ifdef SEQ_MULT_EARLY_DONE_EN
          rem   <= rem >> 1;
`endif
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            p     <= product;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Directed self-checking bench for seq_mult_nbit (N = 4); latency expectations
// follow SEQ_MULT_EARLY_DONE_EN when the bench is built with it.

module tb_seq_mult_nbit;

  localparam int unsigned N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  int checks = 0;
  int errors = 0;

  seq_mult_nbit #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge until done is visible.
  function automatic int exp_lat(input int bv);
`ifdef SEQ_MULT_EARLY_DONE_EN
    int runs;
    runs = 1;
    for (int i = 0; i < int'(N); i++)
      if (bv[i]) runs = i + 1;
    return runs + 1;
`else
    return int'(N) + 1;
`endif
  endfunction

  task automatic run_op(input int av, input int bv, input int ep, input int elat,
                        input string tag);
    int lat;
    int busy_n;
    a     = N'(av);
    b     = N'(bv);
    start = 1'b1;
    step();
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy_cycles"}, busy_n, elat - 1);
    check({tag, "_p"}, int'(p), ep);
    step();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_p_hold"}, int'(p), ep);
  endtask

  initial begin
    int lat;
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset_p", int'(p), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    step();

    run_op(15, 15, 225, 5, "m15x15");
    run_op(7, 0, 0, exp_lat(0), "m7x0");
    run_op(5, 1, 5, exp_lat(1), "m5x1");
    run_op(6, 9, 54, 5, "m6x9");

    // Start held through RUN must not disturb 15x15, then is accepted in DONE.
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    a = 4'd3; b = 4'd4;
    for (int i = 0; i < int'(N) - 1; i++) begin
      step();
      check("hold_busy", int'(busy), 1);
      check("hold_no_done", int'(done), 0);
    end
    step();
    check("hold_first_done", int'(done), 1);
    check("hold_first_p", int'(p), 225);
    step();
    start = 1'b0;
    check("b2b_no_gap_busy", int'(busy), 1);
    check("b2b_done_cleared", int'(done), 0);
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("b2b_lat", lat, exp_lat(4));
    check("b2b_p", int'(p), 12);
    step();

    // Reset in the second RUN cycle of 9x9 aborts without a done pulse.
    a = 4'd9; b = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_abort_p", int'(p), 0);
    check("rst_abort_busy", int'(busy), 0);
    check("rst_abort_done", int'(done), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) pulses++;
    end
    check("rst_abort_no_pulse", pulses, 0);
    check("rst_abort_idle", int'(busy), 0);
    run_op(2, 3, 6, exp_lat(3), "m2x3");

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(i, j, i * j, exp_lat(j), $sformatf("sweep_%0dx%0d", i, j));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_nbit.md
SEQ_MULT_NBIT -- requirements
Module: seq_mult_nbit

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits; legal range N >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to multiply a by b; sampled on clk.
REQ-005 SHALL have port a  input  N  unsigned multiplicand; sampled only when start is accepted.
REQ-006 SHALL have port b  input  N  unsigned multiplier; sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid product.
REQ-009 SHALL have port p  output  2N  unsigned product register.

Function
REQ-010 SHALL implement a shift-and-add multiplier with FSM states IDLE, RUN and DONE.
REQ-011 SHALL perform each partial-product add with one internal instance of the team's N-bit ripple-carry adder with carry-out, with cin tied to 0.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance, latch a, clear the upper accumulator, load b into the lower register, clear the bit counter and enter RUN.
REQ-013 SHALL ignore start while in RUN, with no effect on state, operands or p.
REQ-014 SHALL, in each RUN cycle, form upper + a (adder output plus carry) when the multiplier LSB is 1, otherwise upper + 0, then shift {carry, upper, lower} right by one bit.
REQ-015 SHALL stay in RUN for exactly N cycles, then enter DONE.
REQ-016 SHALL load p with the full 2N-bit product on entry to DONE and hold p until the next DONE entry.
REQ-017 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE unless start is accepted in that cycle.
REQ-018 SHALL assert busy exactly while in RUN.
REQ-019 SHALL, with start sampled high at edge t0, enter RUN at t0 and assert done after edge t0+N (latency N+1 cycles from start to done).
REQ-020 SHALL produce results without overflow: max product (2^N-1)^2 fits in 2N bits.
REQ-021 SHALL, when start is accepted in DONE, pulse done for that single cycle and enter RUN on the next edge (back-to-back operation, no idle gap).

Reset
REQ-022 SHALL, when rst is high at a clock edge, enter IDLE and clear busy, done, p, the counter and all operand and accumulator registers, regardless of state.
REQ-023 SHALL let rst dominate start in the same cycle; an operation interrupted by reset SHALL never produce done.

Configuration
REQ-024 SHALL compile in early termination when macro SEQ_MULT_EARLY_DONE_EN is defined.
REQ-025 SHALL, with SEQ_MULT_EARLY_DONE_EN defined, leave RUN after the cycle that processes the most significant 1 bit of b (one RUN cycle if b = 0), align the product by shifting it right by the number of unprocessed bits before loading p, and thus give latency max(1, msb_index(b)+1) + 1 cycles.
REQ-026 SHALL, without SEQ_MULT_EARLY_DONE_EN, always run exactly N RUN cycles per REQ-015; p values SHALL be identical in both builds.

Verification (N = 4)
REQ-027 SHALL cover: a=15, b=15, start pulse -> done 5 cycles after start, p=225, busy high for 4 cycles.
REQ-028 SHALL cover: a=7, b=0 -> p=0; done after 5 cycles (macro off) or 2 cycles (macro on).
REQ-029 SHALL cover: a=5, b=1 -> p=5; done after 5 cycles (macro off) or 2 cycles (macro on); a=6, b=9 -> p=54 with latency 5 in both builds.
REQ-030 SHALL cover: start held high with a=3, b=4 during RUN of 15x15 -> first result p=225 unaffected; a=3, b=4 accepted in DONE cycle -> p=12 on next done, no idle cycle between.
REQ-031 SHALL cover: rst asserted in the 2nd RUN cycle of 9x9 -> next cycle IDLE, p=0, busy=0, no done pulse; then 2x3 -> p=6.
REQ-032 SHALL cover: exhaustive sweep of all 256 (a, b) pairs -> p equals a*b for every pair, done exactly once per accepted start.
